instr_fetch_decode: RTL and testbench

- Fetch/decode front end that drives the instruction-memory address and consumes the 16-bit word returned combinationally in the same cycle.
- Assembles one- and two-word instructions, splits them into opcode, A/B/C bus-select fields and an immediate, and issues them to the datapath over a valid/ready handshake.
- Resolves JUMPZ/NJUMPZ internally from the datapath zero flag, and stops on OVER.

---
 rtl/instr_fetch_decode.sv | 191 +++++++++++++++++++
 tb/tb_instr_fetch_decode.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_decode.sv
// Fetch/decode front end: walks the program counter through instruction memory,
// assembles one- and two-word instructions, resolves conditional jumps locally
// from the datapath zero flag and hands everything else to the datapath over a
// valid/ready handshake. Stops on OVER, an illegal opcode or an out-of-range address.
module instr_fetch_decode #(
  parameter int ADDR_W     = 16,
  parameter int IMEM_DEPTH = 512,
  parameter int START_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] iram_addr,
  input  logic [15:0]       iram_word,
  input  logic              zero_flag,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [5:0]        op,
  output logic [2:0]        a_sel,
  output logic [2:0]        b_sel,
  output logic [3:0]        c_sel,
  output logic [15:0]       imm,
  output logic              halted,
  output logic              err
);

  localparam logic [5:0] OP_C2R    = 6'd10;
  localparam logic [5:0] OP_JUMPZ  = 6'd14;
  localparam logic [5:0] OP_NJUMPZ = 6'd15;
  localparam logic [5:0] OP_OVER   = 6'd16;

  // Range checks are done 32 bits wide so a depth equal to 2**ADDR_W still works.
  localparam logic [31:0]       DEPTH    = 32'(IMEM_DEPTH);
  localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_FETCH_EXT,
    S_JUMP,
    S_ISSUE,
    S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [15:0]       ext_q, ext_d;
  logic              halted_q, halted_d;
  logic              err_q, err_d;

  logic [5:0] w_op;
  logic [5:0] ir_op;
  logic       w_legal;
  logic       pc_in_range;
  logic       ext_in_range;
  logic       jump_taken;

  assign w_op         = iram_word[15:10];
  assign ir_op        = ir_q[15:10];
  assign w_legal      = (w_op != 6'd0) && (w_op <= OP_OVER);
  assign pc_in_range  = (32'(pc_q) < DEPTH);
  assign ext_in_range = ({16'h0000, ext_q} < DEPTH);
  // JUMPZ branches on zero, NJUMPZ on non-zero.
  assign jump_taken   = (ir_op == OP_JUMPZ) ? zero_flag : ~zero_flag;

  assign iram_addr   = pc_q;
  assign instr_valid = (state_q == S_ISSUE);
  assign halted      = halted_q;
  assign err         = err_q;

  // Field split of the held instruction; fields that an opcode does not use read as zero.
  always_comb begin
    op    = ir_op;
    a_sel = 3'd0;
    b_sel = 3'd0;
    c_sel = 4'd0;
    imm   = 16'h0000;
    if ((ir_op >= 6'd1) && (ir_op <= 6'd9)) begin
      a_sel = ir_q[9:7];
      b_sel = ir_q[6:4];
      c_sel = ir_q[3:0];
    end else if (ir_op == OP_C2R) begin
      c_sel = ir_q[9:6];
      imm   = ext_q;
    end
  end

  // Next-state logic for the fetch/issue sequencer.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    ext_d    = ext_q;
    halted_d = halted_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = START_PC;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (!pc_in_range) begin
          err_d    = 1'b1;
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else begin
          ir_d = iram_word;
          if (!w_legal) begin
            pc_d     = pc_q + ADDR_W'(1);
            err_d    = 1'b1;
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else if (w_op == OP_OVER) begin
            // pc stays on the OVER word so the halt address is visible.
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else begin
            pc_d = pc_q + ADDR_W'(1);
            if ((w_op == OP_C2R) || (w_op == OP_JUMPZ) || (w_op == OP_NJUMPZ)) begin
              state_d = S_FETCH_EXT;
            end else begin
              state_d = S_ISSUE;
            end
          end
        end
      end
      S_FETCH_EXT: begin
        if (!pc_in_range) begin
          err_d    = 1'b1;
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else begin
          ext_d   = iram_word;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = (ir_op == OP_C2R) ? S_ISSUE : S_JUMP;
        end
      end
      S_JUMP: begin
        state_d = S_FETCH;
        if (jump_taken) begin
          if (ext_in_range) begin
            pc_d = ADDR_W'(ext_q);
          end else begin
            err_d    = 1'b1;
            halted_d = 1'b1;
            state_d  = S_HALT;
          end
        end
      end
      S_ISSUE: begin
        if (instr_ready) begin
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        if (start) begin
          pc_d     = START_PC;
          err_d    = 1'b0;
          halted_d = 1'b0;
          state_d  = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, program counter and instruction holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= START_PC;
      ir_q     <= 16'h0000;
      ext_q    <= 16'h0000;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      ext_q    <= ext_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode: a small instruction memory model feeds
// the fetch port combinationally, and each step checks the visible outputs.
module tb_instr_fetch_decode;

  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] iram_addr;
  logic [15:0]       iram_word;
  logic              zero_flag;
  logic              instr_valid;
  logic              instr_ready;
  logic [5:0]        op;
  logic [2:0]        a_sel;
  logic [2:0]        b_sel;
  logic [3:0]        c_sel;
  logic [15:0]       imm;
  logic              halted;
  logic              err;

  logic [15:0] mem [0:1023];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign iram_word = (iram_addr < 16'd1024) ? mem[iram_addr[9:0]] : 16'h0000;

  instr_fetch_decode #(
    .ADDR_W    (16),
    .IMEM_DEPTH(512),
    .START_ADDR(0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .iram_addr  (iram_addr),
    .iram_word  (iram_word),
    .zero_flag  (zero_flag),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .op         (op),
    .a_sel      (a_sel),
    .b_sel      (b_sel),
    .c_sel      (c_sel),
    .imm        (imm),
    .halted     (halted),
    .err        (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance n cycles, checking that nothing is issued on any of them.
  task automatic run_novalid(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(tag, {31'd0, instr_valid}, 32'd0);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    instr_ready = 1'b0;
    zero_flag   = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[0]  = 16'h28C0;  // CONSTANT2REG c=3
    mem[1]  = 16'd1235;
    mem[2]  = 16'h3800;  // JUMPZ 11
    mem[3]  = 16'd11;
    mem[4]  = 16'h3C00;  // NJUMPZ 30
    mem[5]  = 16'd30;
    mem[6]  = 16'h3800;  // JUMPZ 40
    mem[7]  = 16'd40;
    mem[8]  = 16'h3C00;  // NJUMPZ 19
    mem[9]  = 16'd19;
    mem[11] = 16'h05D2;  // ADD a=3 b=5 c=2
    mem[12] = 16'h3800;  // JUMPZ 20
    mem[13] = 16'd20;
    mem[19] = 16'h4000;  // OVER
    mem[20] = 16'h3800;  // JUMPZ 4
    mem[21] = 16'd4;

    // Reset state
    tick();
    tick();
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_op", {26'd0, op}, 32'd0);
    chk("rst_addr", {16'd0, iram_addr}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_no_fetch", {16'd0, iram_addr}, 32'd0);

    // Two-word CONSTANT2REG, valid three cycles after start
    instr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_fetch_addr", {16'd0, iram_addr}, 32'd0);
    chk("t1_novalid1", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("t1_novalid2", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("t1_valid", {31'd0, instr_valid}, 32'd1);
    chk("t1_op", {26'd0, op}, 32'd10);
    chk("t1_c_sel", {28'd0, c_sel}, 32'd3);
    chk("t1_a_sel", {29'd0, a_sel}, 32'd0);
    chk("t1_b_sel", {29'd0, b_sel}, 32'd0);
    chk("t1_imm", {16'd0, imm}, 32'd1235);
    tick();
    chk("t1_valid_drop", {31'd0, instr_valid}, 32'd0);
    chk("t1_addr_after", {16'd0, iram_addr}, 32'd2);

    // JUMPZ 11 taken with zero_flag=1
    run_novalid(3, "j11_novalid");
    chk("j11_addr", {16'd0, iram_addr}, 32'd11);

    // ADD held while ready is low; start pulse here must be ignored
    instr_ready = 1'b0;
    tick();
    chk("t2_valid", {31'd0, instr_valid}, 32'd1);
    chk("t2_op", {26'd0, op}, 32'd1);
    chk("t2_a_sel", {29'd0, a_sel}, 32'd3);
    chk("t2_b_sel", {29'd0, b_sel}, 32'd5);
    chk("t2_c_sel", {28'd0, c_sel}, 32'd2);
    chk("t2_imm", {16'd0, imm}, 32'd0);
    chk("t2_addr", {16'd0, iram_addr}, 32'd12);
    for (int i = 0; i < 2; i++) begin
      start = (i == 0);
      tick();
      start = 1'b0;
      chk("t2_hold_valid", {31'd0, instr_valid}, 32'd1);
      chk("t2_hold_op", {26'd0, op}, 32'd1);
      chk("t2_hold_a", {29'd0, a_sel}, 32'd3);
      chk("t2_hold_b", {29'd0, b_sel}, 32'd5);
      chk("t2_hold_c", {28'd0, c_sel}, 32'd2);
      chk("t2_hold_addr", {16'd0, iram_addr}, 32'd12);
    end
    instr_ready = 1'b1;
    tick();
    chk("t2_valid_drop", {31'd0, instr_valid}, 32'd0);
    chk("t2_addr_after", {16'd0, iram_addr}, 32'd12);

    // Jump chain: 12->20 (JUMPZ, z=1), 20->4 (JUMPZ, z=1), 4->6 (NJUMPZ, z=1 not taken)
    run_novalid(3, "j20_novalid");
    chk("j20_addr", {16'd0, iram_addr}, 32'd20);
    run_novalid(3, "j4_novalid");
    chk("jz_taken_addr", {16'd0, iram_addr}, 32'd4);
    run_novalid(3, "njz_nt_novalid");
    chk("njz_not_taken_addr", {16'd0, iram_addr}, 32'd6);
    zero_flag = 1'b0;
    run_novalid(3, "jz_nt_novalid");
    chk("jz_not_taken_addr", {16'd0, iram_addr}, 32'd8);
    run_novalid(3, "njz_t_novalid");
    chk("njz_taken_addr", {16'd0, iram_addr}, 32'd19);

    // OVER at 19
    tick();
    chk("over_halted", {31'd0, halted}, 32'd1);
    chk("over_err", {31'd0, err}, 32'd0);
    chk("over_valid", {31'd0, instr_valid}, 32'd0);
    chk("over_addr", {16'd0, iram_addr}, 32'd19);
    tick();
    tick();
    chk("over_addr_frozen", {16'd0, iram_addr}, 32'd19);
    chk("over_halted_hold", {31'd0, halted}, 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_addr", {16'd0, iram_addr}, 32'd0);
    chk("restart_halted", {31'd0, halted}, 32'd0);
    tick();
    tick();
    chk("restart_valid", {31'd0, instr_valid}, 32'd1);
    chk("restart_imm", {16'd0, imm}, 32'd1235);

    // Asynchronous reset while an instruction is being issued
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, instr_valid}, 32'd0);
    chk("arst_op", {26'd0, op}, 32'd0);
    chk("arst_c_sel", {28'd0, c_sel}, 32'd0);
    chk("arst_imm", {16'd0, imm}, 32'd0);
    chk("arst_addr", {16'd0, iram_addr}, 32'd0);
    chk("arst_halted", {31'd0, halted}, 32'd0);
    chk("arst_err", {31'd0, err}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("arst_restart_addr", {16'd0, iram_addr}, 32'd0);
    tick();
    chk("arst_restart_pc1", {16'd0, iram_addr}, 32'd1);

    // Illegal opcode 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mem[0] = 16'h0000;
    zero_flag = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("ill_err", {31'd0, err}, 32'd1);
    chk("ill_halted", {31'd0, halted}, 32'd1);
    chk("ill_valid", {31'd0, instr_valid}, 32'd0);

    // Jump target 600 beyond memory
    mem[0] = 16'h3800;
    mem[1] = 16'd600;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("j600_err_clear", {31'd0, err}, 32'd0);
    chk("j600_halted_clear", {31'd0, halted}, 32'd0);
    chk("j600_addr0", {16'd0, iram_addr}, 32'd0);
    run_novalid(3, "j600_novalid");
    chk("j600_err", {31'd0, err}, 32'd1);
    chk("j600_halted", {31'd0, halted}, 32'd1);
    chk("j600_addr_frozen", {16'd0, iram_addr}, 32'd2);

    // Jump to the last word 511, then running off the end at 512
    mem[1] = 16'd511;
    mem[511] = 16'h05D2;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_novalid(3, "j511_novalid");
    chk("j511_addr", {16'd0, iram_addr}, 32'd511);
    chk("j511_err", {31'd0, err}, 32'd0);
    tick();
    chk("last_valid", {31'd0, instr_valid}, 32'd1);
    chk("last_addr", {16'd0, iram_addr}, 32'd512);
    tick();
    chk("last_drop", {31'd0, instr_valid}, 32'd0);
    chk("last_err_clear", {31'd0, err}, 32'd0);
    tick();
    chk("oor_err", {31'd0, err}, 32'd1);
    chk("oor_halted", {31'd0, halted}, 32'd1);
    chk("oor_addr", {16'd0, iram_addr}, 32'd512);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
